// File: rtl/immediate_narrower.sv
// Two-stage narrowing pipeline: stage A captures the wide operand, stage B holds the
// narrowed (optionally saturated) result plus overflow flag and running overflow stats.
module immediate_narrower #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  inp,
  input  logic             signSig,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr,
  output logic             sticky_ovf,
  output logic [7:0]       ovf_count
);

  localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] U_MAX   = {OUT_W{1'b1}};

  logic              a_valid_q, a_valid_d;
  logic [IN_W-1:0]   a_data_q,  a_data_d;
  logic              a_sign_q,  a_sign_d;
  logic              b_valid_q, b_valid_d;
  logic [OUT_W-1:0]  out_q,     out_d;
  logic              ovf_q,     ovf_d;
  logic              sticky_q,  sticky_d;
  logic [7:0]        count_q,   count_d;

  logic              b_accept;
  logic              in_xfer;
  logic              out_xfer;
  logic              fits;
  logic [OUT_W-1:0]  narrow_val;
  logic [IN_W-OUT_W:0]   sig_upper;
  logic [IN_W-OUT_W-1:0] uns_upper;

  assign b_accept  = !b_valid_q || out_ready;
  assign in_ready  = !a_valid_q || b_accept;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = b_valid_q && out_ready;

  assign out       = out_q;
  assign ovf       = ovf_q;
  assign out_valid = b_valid_q;
  assign sticky_ovf = sticky_q;
  assign ovf_count = count_q;

  // Signed fits when every bit from the MSB down to the new sign bit agrees.
  always_comb begin
    sig_upper  = a_data_q[IN_W-1:OUT_W-1];
    uns_upper  = a_data_q[IN_W-1:OUT_W];
    fits       = 1'b1;
    narrow_val = a_data_q[OUT_W-1:0];
    if (a_sign_q) begin
      fits = (&sig_upper) || !(|sig_upper);
    end else begin
      fits = !(|uns_upper);
    end
    if ((SAT != 0) && !fits) begin
      if (a_sign_q) begin
        narrow_val = a_data_q[IN_W-1] ? NEG_MIN : POS_MAX;
      end else begin
        narrow_val = U_MAX;
      end
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_sign_d  = a_sign_q;
    b_valid_d = b_valid_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    if (in_ready) begin
      a_valid_d = in_valid;
    end
    if (in_xfer) begin
      a_data_d = inp;
      a_sign_d = signSig;
    end
    if (b_accept) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        out_d = narrow_val;
        ovf_d = !fits;
      end
    end
  end

  // A clear that lands on an overflowed delivery still records that delivery.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (clr) begin
      sticky_d = out_xfer && ovf_q;
      count_d  = (out_xfer && ovf_q) ? 8'd1 : 8'd0;
    end else if (out_xfer && ovf_q) begin
      sticky_d = 1'b1;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_sign_q  <= 1'b0;
      b_valid_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      a_valid_q <= a_valid_d;
      a_data_q  <= a_data_d;
      a_sign_q  <= a_sign_d;
      b_valid_q <= b_valid_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
      sticky_q  <= sticky_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_immediate_narrower.sv
// Scoreboarded bench for immediate_narrower: a saturating and a truncating instance share
// all inputs; expected results are queued on input transfer and checked on output transfer.
module tb_immediate_narrower;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inp;
  logic        signSig;
  logic        in_valid;
  logic        out_ready;
  logic        clr;

  logic        in_ready, ovf, out_valid, sticky_ovf;
  logic [15:0] out;
  logic [7:0]  ovf_count;
  logic        in_ready0, ovf0, out_valid0, sticky_ovf0;
  logic [15:0] out0;
  logic [7:0]  ovf_count0;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  typedef struct packed {
    logic [15:0] out1;
    logic [15:0] out0;
    logic        ovf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_cnt    = 8'd0;
  logic       exp_sticky = 1'b0;

  always #5 clk = ~clk;

  immediate_narrower #(.IN_W(32), .OUT_W(16), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .signSig(signSig),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready), .clr(clr),
    .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );

  immediate_narrower #(.IN_W(32), .OUT_W(16), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .inp(inp), .signSig(signSig),
    .in_valid(in_valid), .in_ready(in_ready0), .out(out0), .ovf(ovf0),
    .out_valid(out_valid0), .out_ready(out_ready), .clr(clr),
    .sticky_ovf(sticky_ovf0), .ovf_count(ovf_count0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference narrowing done with wide integer range tests.
  function automatic exp_t model(input logic [31:0] v, input logic s);
    exp_t        e;
    longint      sv;
    logic [15:0] low;
    low    = v[15:0];
    e.out0 = low;
    if (s) begin
      sv    = longint'($signed(v));
      e.ovf = (sv > 32767) || (sv < -32768);
      e.out1 = !e.ovf ? low : (sv < 0 ? 16'h8000 : 16'h7FFF);
    end else begin
      e.ovf  = v > 32'h0000FFFF;
      e.out1 = e.ovf ? 16'hFFFF : low;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic xfer_ovf;
    if (rst_n) begin
      check("ovf_count", ovf_count, exp_cnt);
      check("sticky_ovf", sticky_ovf, exp_sticky);
      check("ovf_count_trunc", ovf_count0, exp_cnt);
      check("out_valid_trunc", out_valid0, out_valid);
      check("in_ready_trunc", in_ready0, in_ready);
      xfer_ovf = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_sat", out, e.out1);
          check("ovf_sat", ovf, e.ovf);
          check("out_trunc", out0, e.out0);
          check("ovf_trunc", ovf0, e.ovf);
          xfer_ovf = e.ovf;
          n_out++;
        end
      end
      if (clr) begin
        exp_sticky = xfer_ovf;
        exp_cnt    = xfer_ovf ? 8'd1 : 8'd0;
      end else if (xfer_ovf) begin
        exp_sticky = 1'b1;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
      if (in_valid && in_ready) sb.push_back(model(inp, signSig));
    end else begin
      exp_cnt    = 8'd0;
      exp_sticky = 1'b0;
    end
  end

  // Holds inp/signSig valid until accepted; returns with time at posedge+1.
  task automatic send(input logic [31:0] v, input logic s, output int waited);
    logic acc;
    inp      = v;
    signSig  = s;
    in_valid = 1'b1;
    waited   = 0;
    acc      = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int          w;
    int          idx;
    int          n0;
    logic        acc;
    logic        have;
    logic [15:0] held;
    logic [31:0] vals[4];
    logic [31:0] bp[4];

    rst_n = 1'b0; inp = '0; signSig = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; clr = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, 16'h0000);
    check("rst_ovf", ovf, 1'b0);
    check("rst_sticky", sticky_ovf, 1'b0);
    check("rst_count", ovf_count, 8'd0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("release_in_ready", in_ready, 1'b1);

    // Latency: result appears the edge after stage A captures it.
    send(32'h00007FFF, 1'b1, w);
    check("lat_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1'b1);
    check("lat_out", out, 16'h7FFF);
    check("lat_ovf", ovf, 1'b0);

    // Signed boundary values, back to back.
    vals[0] = 32'h00007FFF; vals[1] = 32'h00008000;
    vals[2] = 32'hFFFF8000; vals[3] = 32'h80000000;
    for (int i = 0; i < 4; i++) begin
      send(vals[i], 1'b1, w);
      check("throughput_wait", w, 1);
    end
    drain();

    // Unsigned boundaries; truncating instance checked by the scoreboard.
    send(32'h0000FFFF, 1'b0, w);
    send(32'h00010000, 1'b0, w);
    send(32'h12345678, 1'b1, w);
    send(32'hFFFFFFFF, 1'b1, w);
    drain();

    // Backpressure: stall five cycles while offering four values.
    bp[0] = 32'h00000001; bp[1] = 32'hFFFFFFFE;
    bp[2] = 32'h00012345; bp[3] = 32'h00007FFF;
    out_ready = 1'b0; idx = 0; have = 1'b0; held = '0;
    for (int c = 0; c < 5; c++) begin
      inp = bp[idx]; signSig = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (out_valid) begin
        if (!have) begin held = out; have = 1'b1; end
        else check("bp_stable", out, held);
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_accepts", idx, 2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    n0 = n_out;
    while (idx < 4) begin
      send(bp[idx], 1'b1, w);
      check("bp_resume_wait", w, 1);
      idx++;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("bp_burst_count", n_out - n0, 4);
    drain();

    // Saturating overflow counter and clear interactions.
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    check("clr_zero", ovf_count, 8'd0);
    for (int i = 0; i < 300; i++) send(32'h80000000, 1'b1, w);
    drain();
    check("count_sat", ovf_count, 8'd255);
    check("sticky_set", sticky_ovf, 1'b1);
    send(32'h80000000, 1'b1, w);
    @(posedge clk); #1;
    check("clr_coincide_valid", out_valid, 1'b1);
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    check("clr_coincide_count", ovf_count, 8'd1);
    check("clr_coincide_sticky", sticky_ovf, 1'b1);
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    check("clr_alone_count", ovf_count, 8'd0);
    check("clr_alone_sticky", sticky_ovf, 1'b0);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(32'h00000011, 1'b0, w);
    send(32'h00000022, 1'b0, w);
    check("full_in_ready", in_ready, 1'b0);
    check("full_out_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_out", out, 16'h0000);
    check("async_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("no_stale", out_valid, 1'b0);
    end
    send(32'h12345678, 1'b0, w);
    check("post_rst_early", out_valid, 1'b0);
    @(posedge clk); #1;
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_out", out, 16'hFFFF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
